pll_audio_ctrl: RTL and testbench

Bring-up and supervision controller for the audio-clock PLL (50 MHz in, ~24.53 MHz out), sitting directly upstream of it in the 50 MHz domain. It drives the PLL reset and the dynamic charge-pump and loop-filter selects. It then waits for a qualified lock, alternating between two loop-filter settings on retries, and reports `ready` or `fail` to the audio subsystem. In READY it keeps watching lock and re-initialises the PLL if lock is lost.

---
 rtl/pll_audio_ctrl_if.sv | 43 ++++
 rtl/pll_audio_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pll_audio_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pll_audio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_audio_ctrl_if
// Purpose  : Control/status bundle between the audio PLL controller and its
//            PLL / audio-subsystem neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface pll_audio_ctrl_if;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic       ready;
  logic       fail;
  logic [3:0] retries;

  modport master (
    input  pll_lock,
    input  restart,
    output pll_reset,
    output icpsel,
    output lpfres,
    output lpfcap,
    output ready,
    output fail,
    output retries
  );

  modport slave (
    output pll_lock,
    output restart,
    input  pll_reset,
    input  icpsel,
    input  lpfres,
    input  lpfcap,
    input  ready,
    input  fail,
    input  retries
  );
endinterface
`default_nettype wire

// File: rtl/pll_audio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_audio_ctrl
// Purpose  : Audio PLL bring-up and supervision: reset sequencing, lock
//            qualification with alternating loop settings, lock-loss recovery.
// Revision : 1.0 - initial release
// ============================================================================
module pll_audio_ctrl #(
  parameter int unsigned RESET_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT = 500_000,
  parameter int unsigned LOCK_STABLE  = 4096,
  parameter int unsigned LOSS_FILTER  = 16,
  parameter int unsigned MAX_RETRIES  = 7,
  parameter logic [5:0]  ICP_SEL      = 6'd12,
  parameter logic [2:0]  LPF_RES      = 3'd3,
  parameter logic [1:0]  LPF_CAP      = 2'd0,
  parameter logic [5:0]  ICP_ALT      = 6'd20,
  parameter logic [2:0]  LPF_RES_ALT  = 3'd5,
  parameter logic [1:0]  LPF_CAP_ALT  = 2'd1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pll_audio_ctrl_if.master bus
);

  localparam int unsigned c_RC_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned c_TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned c_ST_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned c_LF_W = $clog2(LOSS_FILTER + 1);

  localparam logic [c_RC_W-1:0] c_RC_LAST = c_RC_W'(RESET_CYCLES - 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_ST_W-1:0] c_ST_LAST = c_ST_W'(LOCK_STABLE - 1);
  localparam logic [c_LF_W-1:0] c_LF_LAST = c_LF_W'(LOSS_FILTER - 1);
  localparam logic [4:0]        c_MAX_RETRIES = 5'(MAX_RETRIES);

  localparam logic [2:0] c_S_INIT      = 3'd0;
  localparam logic [2:0] c_S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] c_S_STABLE    = 3'd2;
  localparam logic [2:0] c_S_READY     = 3'd3;
  localparam logic [2:0] c_S_FAIL      = 3'd4;

  logic [2:0]        r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [c_RC_W-1:0] r_rc;
  logic [c_TO_W-1:0] r_tcnt;
  logic [c_ST_W-1:0] r_scnt;
  logic [c_LF_W-1:0] r_lcnt;
  logic              r_pll_reset;
  logic [5:0]        r_icpsel;
  logic [2:0]        r_lpfres;
  logic [1:0]        r_lpfcap;
  logic              r_ready;
  logic              r_fail;
  logic [3:0]        r_retries;

  logic [2:0]        w_state_nxt;
  logic              w_lock_s;
  logic [4:0]        w_retry_inc;
  logic              w_give_up;
  logic              w_attempt_fail;
  logic              w_stay;
  logic [c_RC_W-1:0] w_rc_nxt;
  logic [c_TO_W-1:0] w_tcnt_nxt;
  logic [c_ST_W-1:0] w_scnt_nxt;
  logic [c_LF_W-1:0] w_lcnt_nxt;
  logic              w_pll_reset_nxt;
  logic [5:0]        w_icpsel_nxt;
  logic [2:0]        w_lpfres_nxt;
  logic [1:0]        w_lpfcap_nxt;
  logic              w_ready_nxt;
  logic              w_fail_nxt;
  logic [3:0]        w_retries_nxt;

  assign w_lock_s    = r_sync2;
  assign w_retry_inc = {1'b0, r_retries} + 5'd1;
  assign w_give_up   = (w_retry_inc > c_MAX_RETRIES);
  assign w_attempt_fail = ((r_state == c_S_WAIT_LOCK) && !w_lock_s && (r_tcnt == c_TO_LAST))
                       || ((r_state == c_S_STABLE) && !w_lock_s);

  // State register and all registered outputs / counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_S_INIT;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_rc        <= '0;
      r_tcnt      <= '0;
      r_scnt      <= '0;
      r_lcnt      <= '0;
      r_pll_reset <= 1'b1;
      r_icpsel    <= ICP_SEL;
      r_lpfres    <= LPF_RES;
      r_lpfcap    <= LPF_CAP;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_retries   <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_sync1     <= bus.pll_lock;
      r_sync2     <= r_sync1;
      r_rc        <= w_rc_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_scnt      <= w_scnt_nxt;
      r_lcnt      <= w_lcnt_nxt;
      r_pll_reset <= w_pll_reset_nxt;
      r_icpsel    <= w_icpsel_nxt;
      r_lpfres    <= w_lpfres_nxt;
      r_lpfcap    <= w_lpfcap_nxt;
      r_ready     <= w_ready_nxt;
      r_fail      <= w_fail_nxt;
      r_retries   <= w_retries_nxt;
    end
  end

  // Next-state logic; restart overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (bus.restart) begin
      w_state_nxt = c_S_INIT;
    end else if (w_attempt_fail) begin
      w_state_nxt = w_give_up ? c_S_FAIL : c_S_INIT;
    end else begin
      case (r_state)
        c_S_INIT:      if (r_rc == c_RC_LAST) w_state_nxt = c_S_WAIT_LOCK;
        c_S_WAIT_LOCK: if (w_lock_s) w_state_nxt = c_S_STABLE;
        c_S_STABLE:    if (r_scnt == c_ST_LAST) w_state_nxt = c_S_READY;
        c_S_READY:     if (!w_lock_s && (r_lcnt == c_LF_LAST)) w_state_nxt = c_S_INIT;
        c_S_FAIL:      w_state_nxt = c_S_FAIL;
        default:       w_state_nxt = c_S_INIT;
      endcase
    end
  end

  // Counters restart from zero on every state change, so none can wrap
  always_comb begin
    w_stay     = (w_state_nxt == r_state) && !bus.restart;
    w_rc_nxt   = ((r_state == c_S_INIT) && w_stay) ? r_rc + c_RC_W'(1) : '0;
    w_tcnt_nxt = ((r_state == c_S_WAIT_LOCK) && w_stay) ? r_tcnt + c_TO_W'(1) : '0;
    w_scnt_nxt = ((r_state == c_S_STABLE) && w_stay) ? r_scnt + c_ST_W'(1) : '0;
    w_lcnt_nxt = ((r_state == c_S_READY) && w_stay && !w_lock_s) ? r_lcnt + c_LF_W'(1) : '0;

    w_retries_nxt = r_retries;
    if (bus.restart) begin
      w_retries_nxt = 4'd0;
    end else if (w_attempt_fail) begin
      w_retries_nxt = w_retry_inc[4] ? 4'hF : w_retry_inc[3:0];
    end

    w_pll_reset_nxt = (w_state_nxt == c_S_INIT) || (w_state_nxt == c_S_FAIL);
    w_ready_nxt     = (w_state_nxt == c_S_READY);
    w_fail_nxt      = (w_state_nxt == c_S_FAIL);

    // Odd attempt numbers use the alternate loop filter
    w_icpsel_nxt = r_icpsel;
    w_lpfres_nxt = r_lpfres;
    w_lpfcap_nxt = r_lpfcap;
    if (r_state == c_S_INIT) begin
      if (w_retries_nxt[0]) begin
        w_icpsel_nxt = ICP_ALT;
        w_lpfres_nxt = LPF_RES_ALT;
        w_lpfcap_nxt = LPF_CAP_ALT;
      end else begin
        w_icpsel_nxt = ICP_SEL;
        w_lpfres_nxt = LPF_RES;
        w_lpfcap_nxt = LPF_CAP;
      end
    end
  end

  assign bus.pll_reset = r_pll_reset;
  assign bus.icpsel    = r_icpsel;
  assign bus.lpfres    = r_lpfres;
  assign bus.lpfcap    = r_lpfcap;
  assign bus.ready     = r_ready;
  assign bus.fail      = r_fail;
  assign bus.retries   = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_pll_audio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_audio_ctrl
// Purpose  : Self-checking bench for pll_audio_ctrl with small parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_audio_ctrl;

  logic clk = 1'b0;
  logic reset;

  pll_audio_ctrl_if bus();

  pll_audio_ctrl #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .LOSS_FILTER  (3),
    .MAX_RETRIES  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observed vector: {pll_reset, ready, fail, retries[3:0], icpsel, lpfres, lpfcap}
  typedef struct {
    logic        lock;
    logic        restart;
    logic [17:0] exp;
  } vec_t;

  localparam logic [10:0] c_PRI = {6'd12, 3'd3, 2'd0};
  localparam logic [10:0] c_ALT = {6'd20, 3'd5, 2'd1};

  vec_t        vecs[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [17:0] w_obs;

  assign w_obs = {bus.pll_reset, bus.ready, bus.fail, bus.retries,
                  bus.icpsel, bus.lpfres, bus.lpfcap};

  function automatic logic [17:0] ex(input logic pr, input logic rdy, input logic fl,
                                     input logic [3:0] ret, input logic [10:0] sel);
    return {pr, rdy, fl, ret, sel};
  endfunction

  function automatic void add(input logic lock, input logic rst_req, input logic [17:0] e);
    vec_t v;
    v.lock    = lock;
    v.restart = rst_req;
    v.exp     = e;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [17:0] e);
    n_total++;
    if (w_obs === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got pr=%0b rdy=%0b fail=%0b ret=%0d sel=%03h, expected pr=%0b rdy=%0b fail=%0b ret=%0d sel=%03h",
               name, w_obs[17], w_obs[16], w_obs[15], w_obs[14:11], w_obs[10:0],
               e[17], e[16], e[15], e[14:11], e[10:0]);
    end
  endtask

  // After this returns, the next rising edge is edge 1
  task automatic do_reset(input logic lock);
    reset        = 1'b1;
    bus.restart  = 1'b0;
    bus.pll_lock = lock;
    step();
    step();
    check("reset_values", ex(1'b1, 1'b0, 1'b0, 4'd0, c_PRI));
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;

    // Row n: inputs during the cycle ending at edge n, outputs after edge n
    for (int i = 1; i <= 3; i++)  add(1'b1, 1'b0, ex(1'b1, 1'b0, 1'b0, 4'd0, c_PRI));
    add(1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd0, c_PRI));                  // edge 4
    for (int i = 5; i <= 12; i++) add(1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd0, c_PRI));
    for (int i = 13; i <= 14; i++) add(1'b1, 1'b0, ex(1'b0, 1'b1, 1'b0, 4'd0, c_PRI));
    for (int i = 15; i <= 16; i++) add(1'b0, 1'b0, ex(1'b0, 1'b1, 1'b0, 4'd0, c_PRI));
    for (int i = 17; i <= 20; i++) add(1'b1, 1'b0, ex(1'b0, 1'b1, 1'b0, 4'd0, c_PRI));
    for (int i = 21; i <= 23; i++) add(1'b0, 1'b0, ex(1'b0, 1'b1, 1'b0, 4'd0, c_PRI));
    add(1'b1, 1'b0, ex(1'b0, 1'b1, 1'b0, 4'd0, c_PRI));                  // edge 24
    add(1'b1, 1'b0, ex(1'b1, 1'b0, 1'b0, 4'd0, c_PRI));                  // edge 25: loss
    add(1'b1, 1'b0, ex(1'b1, 1'b0, 1'b0, 4'd0, c_PRI));                  // edge 26

    // Clean lock, short dropout, then a real lock loss
    do_reset(1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.pll_lock = vecs[i].lock;
      bus.restart  = vecs[i].restart;
      step();
      check($sformatf("vec_edge%0d", i + 1), vecs[i].exp);
    end

    // Timeouts with alternating settings, then FAIL
    do_reset(1'b0);
    repeat (23) step();
    check("to_edge23", ex(1'b0, 1'b0, 1'b0, 4'd0, c_PRI));
    step();
    check("to_edge24", ex(1'b1, 1'b0, 1'b0, 4'd1, c_PRI));
    step();
    check("to_edge25_alt", ex(1'b1, 1'b0, 1'b0, 4'd1, c_ALT));
    repeat (3) step();
    check("to_edge28", ex(1'b0, 1'b0, 1'b0, 4'd1, c_ALT));
    repeat (20) step();
    check("to_edge48", ex(1'b1, 1'b0, 1'b0, 4'd2, c_ALT));
    step();
    check("to_edge49_pri", ex(1'b1, 1'b0, 1'b0, 4'd2, c_PRI));
    repeat (3) step();
    check("to_edge52", ex(1'b0, 1'b0, 1'b0, 4'd2, c_PRI));
    repeat (19) step();
    check("to_edge71", ex(1'b0, 1'b0, 1'b0, 4'd2, c_PRI));
    step();
    check("to_edge72_fail", ex(1'b1, 1'b0, 1'b1, 4'd3, c_PRI));
    bus.pll_lock = 1'b1;
    repeat (4) step();
    check("fail_hold", ex(1'b1, 1'b0, 1'b1, 4'd3, c_PRI));

    // Restart out of FAIL with lock already high
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    check("restart_edge", ex(1'b1, 1'b0, 1'b0, 4'd0, c_PRI));
    repeat (12) step();
    check("restart_plus12", ex(1'b0, 1'b0, 1'b0, 4'd0, c_PRI));
    step();
    check("restart_plus13", ex(1'b0, 1'b1, 1'b0, 4'd0, c_PRI));

    // One-cycle glitch at stable count 5, then recovery on alternate settings
    do_reset(1'b1);
    repeat (8) step();
    bus.pll_lock = 1'b0;
    step();
    bus.pll_lock = 1'b1;
    step();
    check("gl_edge10", ex(1'b0, 1'b0, 1'b0, 4'd0, c_PRI));
    step();
    check("gl_edge11", ex(1'b1, 1'b0, 1'b0, 4'd1, c_PRI));
    step();
    check("gl_edge12_alt", ex(1'b1, 1'b0, 1'b0, 4'd1, c_ALT));
    repeat (11) step();
    check("gl_edge23", ex(1'b0, 1'b0, 1'b0, 4'd1, c_ALT));
    step();
    check("gl_edge24", ex(1'b0, 1'b1, 1'b0, 4'd1, c_ALT));

    // Reset together with restart while in STABLE
    do_reset(1'b1);
    repeat (8) step();
    bus.pll_lock = 1'b0;
    step();
    bus.pll_lock = 1'b1;
    repeat (8) step();
    check("mr_stable", ex(1'b0, 1'b0, 1'b0, 4'd1, c_ALT));
    reset       = 1'b1;
    bus.restart = 1'b1;
    step();
    check("mr_reset_vals", ex(1'b1, 1'b0, 1'b0, 4'd0, c_PRI));
    reset       = 1'b0;
    bus.restart = 1'b0;
    repeat (12) step();
    check("mr_edge12", ex(1'b0, 1'b0, 1'b0, 4'd0, c_PRI));
    step();
    check("mr_edge13", ex(1'b0, 1'b1, 1'b0, 4'd0, c_PRI));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
